// File: rtl/adpll_ctrl_param.sv
// adpll_ctrl_param: ADPLL loop controller between PFD and DCO.
// One PFD decision is taken per reference edge. A binary search acquires
// frequency first, then linear tracking follows the phase, with lock/unlock
// detection and automatic re-acquisition when the code hits either rail.
//
// Decision strobe semantics: there is no valid/ready pair. Every rising clk
// edge with start=1 consumes exactly one decision. p_up&~p_down is UP,
// p_down&~p_up is DN, and both-or-neither is HOLD, which changes nothing.
// All outputs are registered and reflect that decision one edge later.
// The FSM is exposed on the 'state' output.
module adpll_ctrl_param #(
  parameter int CODE_W     = 7,
  parameter int TRACK_STEP = 1,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_RUN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              p_up,
  input  logic              p_down,
  output logic [CODE_W-1:0] dco_code,
  output logic              freq_lock,
  output logic              phase_lock,
  output logic              polarity,
  output logic [1:0]        state
);

  localparam int REV_W = $clog2(LOCK_CNT + 1);
  localparam int RUN_W = $clog2(UNLOCK_RUN + 1);

  localparam logic [CODE_W-1:0] CODE_MID = CODE_W'(1) << (CODE_W - 1);
  localparam logic [CODE_W-1:0] CODE_MAX = {CODE_W{1'b1}};
  localparam logic [CODE_W-2:0] STEP_INIT = (CODE_W - 1)'(1) << (CODE_W - 2);
  localparam logic [CODE_W-1:0] TSTEP = CODE_W'(TRACK_STEP);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_TRACK  = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-2:0] step_q, step_d;
  logic              flock_q, flock_d;
  logic              plock_q, plock_d;
  logic              pol_q, pol_d;
  logic [REV_W-1:0]  rev_q, rev_d;
  logic [RUN_W-1:0]  run_q, run_d;

  logic              dec_up, dec_dn, dec_any;
  logic              at_rail, reversal;
  logic [CODE_W:0]   sum_up;
  logic [CODE_W-1:0] code_inc, code_dec;
  logic [REV_W-1:0]  rev_inc;
  logic [RUN_W-1:0]  run_inc;

  // Decode the PFD decision and precompute saturating tracking moves.
  always_comb begin
    dec_up   = p_up & ~p_down;
    dec_dn   = p_down & ~p_up;
    dec_any  = dec_up | dec_dn;
    at_rail  = (dec_up && (code_q == CODE_MAX)) || (dec_dn && (code_q == '0));
    reversal = (dec_up != pol_q);
    sum_up   = {1'b0, code_q} + {1'b0, TSTEP};
    code_inc = (sum_up > {1'b0, CODE_MAX}) ? CODE_MAX : sum_up[CODE_W-1:0];
    code_dec = (code_q < TSTEP) ? '0 : (code_q - TSTEP);
    rev_inc  = rev_q + REV_W'(1);
    run_inc  = run_q + RUN_W'(1);
  end

  // Next-state and datapath update; start=0 overrides any decision.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    step_d  = step_q;
    flock_d = flock_q;
    plock_d = plock_q;
    pol_d   = pol_q;
    rev_d   = rev_q;
    run_d   = run_q;
    if (!start) begin
      state_d = S_IDLE;
      flock_d = 1'b0;
      plock_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_SEARCH;
          code_d  = CODE_MID;
          step_d  = STEP_INIT;
          rev_d   = '0;
          run_d   = '0;
        end
        S_SEARCH: begin
          if (dec_any) begin
            code_d = dec_up ? (code_q + {1'b0, step_q}) : (code_q - {1'b0, step_q});
            pol_d  = dec_up;
            step_d = step_q >> 1;
            // The unit-step decision is the last one of the binary search.
            if (step_q == (CODE_W - 1)'(1)) begin
              state_d = S_TRACK;
              flock_d = 1'b1;
              rev_d   = '0;
            end
          end
        end
        S_TRACK, S_LOCKED: begin
          if (dec_any) begin
            if (at_rail) begin
              // Pushed against a rail: frequency is lost, re-acquire from MID.
              state_d = S_SEARCH;
              code_d  = CODE_MID;
              step_d  = STEP_INIT;
              flock_d = 1'b0;
              plock_d = 1'b0;
              rev_d   = '0;
              run_d   = '0;
            end else begin
              code_d = dec_up ? code_inc : code_dec;
              pol_d  = dec_up;
              if (state_q == S_TRACK) begin
                if (reversal) begin
                  if (rev_inc == REV_W'(LOCK_CNT)) begin
                    state_d = S_LOCKED;
                    plock_d = 1'b1;
                    run_d   = '0;
                    rev_d   = '0;
                  end else begin
                    rev_d = rev_inc;
                  end
                end else begin
                  rev_d = '0;
                end
              end else begin
                if (!reversal) begin
                  if (run_inc == RUN_W'(UNLOCK_RUN)) begin
                    state_d = S_TRACK;
                    plock_d = 1'b0;
                    rev_d   = '0;
                    run_d   = '0;
                  end else begin
                    run_d = run_inc;
                  end
                end else begin
                  run_d = '0;
                end
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      code_q  <= CODE_MID;
      step_q  <= STEP_INIT;
      flock_q <= 1'b0;
      plock_q <= 1'b0;
      pol_q   <= 1'b0;
      rev_q   <= '0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      step_q  <= step_d;
      flock_q <= flock_d;
      plock_q <= plock_d;
      pol_q   <= pol_d;
      rev_q   <= rev_d;
      run_q   <= run_d;
    end
  end

  assign dco_code   = code_q;
  assign freq_lock  = flock_q;
  assign phase_lock = plock_q;
  assign polarity   = pol_q;
  assign state      = state_q;

endmodule
